game_flow_ctrl: RTL
===================

# game_flow_ctrl

Top-level game sequencer for the rhythm game. It drives the shared 3-bit `mode` bus consumed by the high-score/display unit, the note engine and the score counters, walking through IDLE → COUNTDOWN → PLAY ⇄ PAUSE → FINISH. It clears the per-game counters at game start and generates the display-cycle pulse `score_tog` from the display button. In FINISH it also auto-rotates the score display.

## Interface
- `CLK_DIV`, default 10_000_000: clk cycles per game second. Must be ≥ 2.
- `COUNT_SECS`, default 3: countdown length in seconds. Legal range 1–3.
- `ROTATE_SECS`, default 2: auto-rotate period in FINISH, in seconds. Must be ≥ 1.
- `clk` in 1: system clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start_btn` in 1: start/abort button, synchronized level.
- `pause_btn` in 1: pause/resume button, synchronized level.
- `disp_btn` in 1: display-cycle button, synchronized level.
- `song_done` in 1: one-cycle pulse from the note engine at end of chart.
- `mode` out 3: game state encoding (see Operation).
- `clr_counts` out 1: one-cycle pulse that clears score/hits/misses.
- `score_tog` out 1: one-cycle pulse that advances the display page.
- `countdown` out 2: seconds remaining in COUNTDOWN; 0 in every other state.

## Operation
- Mode encodings: IDLE=3'b000, COUNTDOWN=3'b001, PLAY=3'b010, PAUSE=3'b011, FINISH=3'b101. Code 3'b100 is never driven.
- Button edges: a rising edge is `btn`=1 while its previous-sample register is 0. Previous-sample registers reset to 1, so a button held through reset produces no edge.
- Second prescaler: counts 0..CLK_DIV-1 and produces `sec_tick` when the count equals CLK_DIV-1. It clears to 0 on every state change and on a manual `disp_btn` edge in FINISH.
- IDLE:
  - start edge → COUNTDOWN, with `clr_counts`=1 and `countdown`=COUNT_SECS.
  - pause and `song_done` are ignored.
- COUNTDOWN:
  - `sec_tick` decrements `countdown`.
  - `sec_tick` with `countdown`==1 → PLAY, `countdown`=0.
  - start and pause edges are ignored.
- PLAY:
  - `song_done` → FINISH.
  - Otherwise a pause edge → PAUSE.
  - `song_done` wins when it coincides with a pause edge.
- PAUSE:
  - pause edge → PLAY.
  - start edge → IDLE (abort, no `clr_counts`).
  - If start and pause edges coincide, start wins.
  - `song_done` is ignored.
- FINISH:
  - start edge → COUNTDOWN with `clr_counts`=1 (new game).
  - Rotation counter counts `sec_tick`s; on reaching ROTATE_SECS it pulses `score_tog` and reloads to 0.
  - Outside FINISH the rotation counter is held at 0.
- `score_tog`: pulses on any `disp_btn` edge in any state. In FINISH a manual edge also restarts the prescaler and rotation counter. A manual edge coinciding with an auto pulse yields exactly one pulse.

## Timing
- All outputs are registered. Reset values: `mode`=IDLE, `clr_counts`=0, `score_tog`=0, `countdown`=0.
- An input event sampled at clock edge N is visible on the outputs after edge N, i.e. one-cycle latency.
- `clr_counts` is high for exactly the first cycle in which `mode`=COUNTDOWN.
- COUNTDOWN lasts exactly COUNT_SECS×CLK_DIV cycles. `countdown` holds each value for CLK_DIV cycles.
- FINISH is held for at least one cycle, so the high-score unit always samples it.
- Asserting `n_rst` in any state returns to reset values immediately. There is no resumption after reset.

## Structure
- Shared package `game_pkg`:
  - `mode_t` enum (logic [2:0]) holding the five encodings above, including FINISH=3'b101, which the high-score unit also uses.
  - Display-page constants.
- Sub-module `btn_edge`: previous-sample register (reset to 1) plus rising-edge pulse. Instantiated three times.
- Top level contains the state register, prescaler, countdown counter and rotation counter.

## Test plan
Parameters for all scenarios: CLK_DIV=4, COUNT_SECS=3, ROTATE_SECS=2.
- `start_btn` high through reset release → `mode` stays IDLE. Release then press → COUNTDOWN next cycle, `clr_counts` high 1 cycle, `countdown`=3.
- After entering COUNTDOWN: `countdown` reads 3,3,3,3,2,2,2,2,1,1,1,1. Cycle 12 → `mode`=PLAY, `countdown`=0. Start and pause presses during the countdown change nothing.
- PLAY:
  - pause edge → PAUSE.
  - `song_done` pulse in PAUSE → still PAUSE.
  - pause → PLAY, then pause → PAUSE.
  - start → IDLE, with `clr_counts` never asserted.
- PLAY with `song_done` and a pause edge in the same cycle → FINISH, not PAUSE.
- FINISH auto-rotate:
  - `score_tog` pulses every 8 cycles.
  - `disp_btn` edge 5 cycles after a pulse → pulse next cycle, and the next auto pulse comes 8 cycles later.
  - Forced coincidence of manual and auto → exactly one pulse.
- FINISH:
  - start → COUNTDOWN with `clr_counts`.
  - `n_rst` asserted mid-COUNTDOWN → `mode`=IDLE and `countdown`=0 immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: mode bus encoding and display page numbering.
// Latency: none (types and constants only).
// Backpressure: none.
package game_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE      = 3'b000,
    MODE_COUNTDOWN = 3'b001,
    MODE_PLAY      = 3'b010,
    MODE_PAUSE     = 3'b011,
    MODE_FINISH    = 3'b101
  } mode_t;

  // Pages cycled through by the high-score/display unit on each score_tog.
  localparam logic [1:0] PAGE_SCORE  = 2'd0;
  localparam logic [1:0] PAGE_HITS   = 2'd1;
  localparam logic [1:0] PAGE_MISSES = 2'd2;
  localparam int         NUM_PAGES   = 3;

endpackage

// File: rtl/game_flow_ctrl_btn_edge.sv
// Rising-edge detector for an already-synchronized button level.
// Latency: combinational pulse in the cycle the level first reads 1.
// Backpressure: none; the previous sample resets to 1 so a held button is no edge.
module btn_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic btn,
  output logic rise
);

  logic prev;

  // Remember last cycle's level; reset high so a button held through reset is ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev <= 1'b1;
    else        prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> FINISH, with count clear and display paging.
// Latency: one cycle from a sampled input event to every (registered) output.
// Backpressure: none; buttons are edge-detected levels, song_done is a single-cycle pulse.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int CLK_DIV     = 10_000_000,
  parameter int COUNT_SECS  = 3,
  parameter int ROTATE_SECS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       disp_btn,
  input  logic       song_done,
  output logic [2:0] mode,
  output logic       clr_counts,
  output logic       score_tog,
  output logic [1:0] countdown
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int RW = $clog2(ROTATE_SECS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] ROT_MAX   = RW'(ROTATE_SECS - 1);
  localparam logic [1:0]    CD_INIT   = 2'(COUNT_SECS);

  mode_t         state;
  mode_t         next_state;
  logic [PW-1:0] presc;
  logic [RW-1:0] rot;
  logic [1:0]    cd_q;

  logic start_rise;
  logic pause_rise;
  logic disp_rise;
  logic sec_tick;
  logic state_chg;
  logic stay_finish;
  logic man_restart;
  logic auto_tog;

  btn_edge u_start (.clk(clk), .n_rst(n_rst), .btn(start_btn), .rise(start_rise));
  btn_edge u_pause (.clk(clk), .n_rst(n_rst), .btn(pause_btn), .rise(pause_rise));
  btn_edge u_disp  (.clk(clk), .n_rst(n_rst), .btn(disp_btn),  .rise(disp_rise));

  assign sec_tick    = (presc == PRESC_MAX);
  assign state_chg   = (next_state != state);
  assign stay_finish = (state == MODE_FINISH) && (next_state == MODE_FINISH);
  // A manual page flip in FINISH restarts the auto-rotate timeline from zero.
  assign man_restart = stay_finish && disp_rise;
  assign auto_tog    = stay_finish && sec_tick && (rot == ROT_MAX);

  // Next-state selection; priorities encode which event wins on coincidence.
  always_comb begin
    next_state = state;
    case (state)
      MODE_IDLE:      if (start_rise) next_state = MODE_COUNTDOWN;
      MODE_COUNTDOWN: if (sec_tick && (cd_q == 2'd1)) next_state = MODE_PLAY;
      MODE_PLAY: begin
        if (song_done)       next_state = MODE_FINISH;
        else if (pause_rise) next_state = MODE_PAUSE;
      end
      MODE_PAUSE: begin
        if (start_rise)      next_state = MODE_IDLE;
        else if (pause_rise) next_state = MODE_PLAY;
      end
      MODE_FINISH:    if (start_rise) next_state = MODE_COUNTDOWN;
      default:        next_state = MODE_IDLE;
    endcase
  end

  // State register; it drives the mode bus directly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= MODE_IDLE;
    else        state <= next_state;
  end

  // Second prescaler, realigned on every state change and manual flip in FINISH.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                       presc <= '0;
    else if (state_chg || man_restart) presc <= '0;
    else if (sec_tick)                presc <= '0;
    else                              presc <= presc + 1'b1;
  end

  // Auto-rotate seconds counter, active only while remaining in FINISH.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                          rot <= '0;
    else if (!stay_finish || man_restart) rot <= '0;
    else if (sec_tick)                   rot <= (rot == ROT_MAX) ? '0 : rot + 1'b1;
  end

  // Registered pulses and countdown value presented with the new state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clr_counts <= 1'b0;
      score_tog  <= 1'b0;
      cd_q       <= 2'd0;
    end else begin
      clr_counts <= (next_state == MODE_COUNTDOWN) && (state != MODE_COUNTDOWN);
      score_tog  <= disp_rise | auto_tog;
      if (next_state != MODE_COUNTDOWN)  cd_q <= 2'd0;
      else if (state != MODE_COUNTDOWN) cd_q <= CD_INIT;
      else if (sec_tick)                cd_q <= cd_q - 2'd1;
    end
  end

  assign mode      = state;
  assign countdown = cd_q;

endmodule
